instr_fetch_sequencer: RTL and testbench

Program-counter and fetch sequencer for the segmented processor's instruction ROM (32 x 32-bit, 5-bit word address, combinational read). It drives the ROM address and captures the ROM word into the IF/ID pipeline register. It handles stalls, taken-branch redirects with a one-slot flush, PC wrap-around, and a halt/resume control. It sits between the ROM and the decode stage; the hazard unit and EX-stage branch logic drive its control inputs.

---
 rtl/instr_fetch_sequencer.sv | 77 +++++++
 tb/tb_instr_fetch_sequencer.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: PC and fetch sequencer feeding the IF/ID register from the instruction ROM
module instr_fetch_sequencer #(
    parameter int              AW       = 5,
    parameter int              DW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0,
    parameter logic [DW-1:0]   NOP_WORD = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_i,
    input  logic          branch_taken_i,
    input  logic [AW-1:0] branch_target_i,
    input  logic          halt_req_i,
    input  logic          resume_i,
    output logic [AW-1:0] rom_addr_o,
    input  logic [DW-1:0] rom_data_i,
    output logic [DW-1:0] ifid_instr_o,
    output logic [AW-1:0] ifid_pc_o,
    output logic          ifid_valid_o,
    output logic          halted_o,
    output logic [15:0]   fetch_count_o
);
    typedef enum logic [1:0] {WARMUP, RUN, HALT} state_t;

    state_t        state;
    logic [AW-1:0] pc;

    assign rom_addr_o = pc;

    // Sequencer: reset, warm-up bubble, then branch > halt > stall > fetch while running
    always_ff @(posedge clk) begin
        if (reset) begin
            pc            <= RESET_PC;
            state         <= WARMUP;
            ifid_instr_o  <= NOP_WORD;
            ifid_pc_o     <= '0;
            ifid_valid_o  <= 1'b0;
            halted_o      <= 1'b0;
            fetch_count_o <= '0;
        end else begin
            case (state)
                WARMUP: begin
                    state        <= RUN;
                    ifid_valid_o <= 1'b0;
                end
                RUN: begin
                    if (branch_taken_i) begin
                        pc           <= branch_target_i;
                        ifid_instr_o <= NOP_WORD;
                        ifid_valid_o <= 1'b0;
                        ifid_pc_o    <= pc;
                    end else if (halt_req_i) begin
                        state        <= HALT;
                        halted_o     <= 1'b1;
                        ifid_instr_o <= NOP_WORD;
                        ifid_valid_o <= 1'b0;
                    end else if (!stall_i) begin
                        pc            <= pc + 1'b1;
                        ifid_instr_o  <= rom_data_i;
                        ifid_pc_o     <= pc;
                        ifid_valid_o  <= 1'b1;
                        fetch_count_o <= fetch_count_o + {15'd0, fetch_count_o != 16'hFFFF};
                    end
                end
                HALT: begin
                    ifid_valid_o <= 1'b0;
                    if (branch_taken_i) pc <= branch_target_i;
                    if (resume_i) begin
                        state    <= RUN;
                        halted_o <= 1'b0;
                    end
                end
                default: state <= WARMUP;
            endcase
        end
    end
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: directed plan plus random stimulus against a behavioural fetch model
module tb_instr_fetch_sequencer;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall_i = 1'b0, branch_taken_i = 1'b0, halt_req_i = 1'b0, resume_i = 1'b0;
    logic [4:0]  branch_target_i = '0;
    logic [4:0]  rom_addr_o, ifid_pc_o;
    logic [31:0] rom_data_i, ifid_instr_o;
    logic        ifid_valid_o, halted_o;
    logic [15:0] fetch_count_o;
    logic [31:0] rom [32];

    int n_chk = 0, n_pass = 0;

    logic [4:0]  m_pc, m_ipc;
    logic [31:0] m_instr;
    logic        m_valid, m_halted, m_warm;
    int          m_cnt;

    instr_fetch_sequencer dut (
        .clk(clk), .reset(reset), .stall_i(stall_i), .branch_taken_i(branch_taken_i),
        .branch_target_i(branch_target_i), .halt_req_i(halt_req_i), .resume_i(resume_i),
        .rom_addr_o(rom_addr_o), .rom_data_i(rom_data_i), .ifid_instr_o(ifid_instr_o),
        .ifid_pc_o(ifid_pc_o), .ifid_valid_o(ifid_valid_o), .halted_o(halted_o),
        .fetch_count_o(fetch_count_o)
    );

    assign rom_data_i = rom[rom_addr_o];

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    endtask

    // One clock: drive inputs, advance the model by the spec rules, compare every output
    task automatic step(input logic r, input logic st, input logic bt, input logic [4:0] tgt,
                        input logic hr, input logic rs);
        @(negedge clk);
        reset = r; stall_i = st; branch_taken_i = bt; branch_target_i = tgt;
        halt_req_i = hr; resume_i = rs;
        @(posedge clk);
        if (r) begin
            m_pc = 5'd0; m_warm = 1'b1; m_instr = '0; m_ipc = '0;
            m_valid = 1'b0; m_halted = 1'b0; m_cnt = 0;
        end else if (m_warm) begin
            m_warm = 1'b0; m_valid = 1'b0;
        end else if (m_halted) begin
            if (bt) m_pc = tgt;
            if (rs) m_halted = 1'b0;
        end else if (bt) begin
            m_ipc = m_pc; m_pc = tgt; m_instr = '0; m_valid = 1'b0;
        end else if (hr) begin
            m_halted = 1'b1; m_valid = 1'b0; m_instr = '0;
        end else if (!st) begin
            m_instr = rom[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
            m_pc = m_pc + 5'd1;
            if (m_cnt < 65535) m_cnt++;
        end
        #1;
        chk("rom_addr", 32'(rom_addr_o), 32'(m_pc));
        chk("ifid_instr", ifid_instr_o, m_instr);
        chk("ifid_pc", 32'(ifid_pc_o), 32'(m_ipc));
        chk("ifid_valid", 32'(ifid_valid_o), 32'(m_valid));
        chk("halted", 32'(halted_o), 32'(m_halted));
        chk("fetch_count", 32'(fetch_count_o), m_cnt);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        for (int k = 0; k < 32; k++) rom[k] = 32'h100 + k;
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("rst_valid", 32'(ifid_valid_o), 32'd0);
        chk("rst_count", 32'(fetch_count_o), 32'd0);
        step(0, 0, 1, 5'd9, 0, 0);
        chk("warm_valid", 32'(ifid_valid_o), 32'd0);
        chk("warm_addr", 32'(rom_addr_o), 32'd0);
        run(5);
        chk("p1_count", 32'(fetch_count_o), 32'd5);
        chk("p1_instr", ifid_instr_o, 32'h104);
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
        chk("p3_pc", 32'(ifid_pc_o), 32'd4);
        chk("p3_addr", 32'(rom_addr_o), 32'd5);
        chk("p3_count", 32'(fetch_count_o), 32'd5);
        run(1);
        chk("p3_next", 32'(ifid_pc_o), 32'd5);
        run(1);
        step(0, 1, 1, 5'd20, 0, 0);
        chk("p4_flush_v", 32'(ifid_valid_o), 32'd0);
        chk("p4_flush_i", ifid_instr_o, 32'd0);
        run(1);
        chk("p4_target", 32'(ifid_pc_o), 32'd20);
        chk("p4_valid", 32'(ifid_valid_o), 32'd1);
        run(11);
        chk("p2_last", 32'(ifid_pc_o), 32'd31);
        chk("p2_wrap_addr", 32'(rom_addr_o), 32'd0);
        run(1);
        chk("p2_wrap_pc", 32'(ifid_pc_o), 32'd0);
        run(9);
        chk("p5_addr", 32'(rom_addr_o), 32'd10);
        step(0, 0, 0, 0, 1, 0);
        chk("p5_halted", 32'(halted_o), 32'd1);
        for (int i = 0; i < 4; i++) step(0, i[0], 0, 0, i[1], 0);
        chk("p5_hold", 32'(rom_addr_o), 32'd10);
        chk("p5_idle_v", 32'(ifid_valid_o), 32'd0);
        step(0, 0, 1, 5'd3, 0, 1);
        chk("p5_resumed", 32'(halted_o), 32'd0);
        run(1);
        chk("p5_target", 32'(ifid_pc_o), 32'd3);
        step(0, 0, 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        chk("p6_halt_rst", 32'(halted_o), 32'd0);
        chk("p6_cnt_rst", 32'(fetch_count_o), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        run(2);
        step(0, 1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 0);
        chk("p6_stall_rst", 32'(rom_addr_o), 32'd0);
        step(0, 0, 0, 0, 0, 0);
        chk("p6_warm", 32'(ifid_valid_o), 32'd0);
        run(1);
        chk("p6_first", 32'(ifid_pc_o), 32'd0);
        chk("p6_first_v", 32'(ifid_valid_o), 32'd1);
        for (int i = 0; i < 3000; i++) begin
            logic r;
            r = ($urandom_range(63) == 0);
            if (r) for (int k = 0; k < 32; k++) rom[k] = $urandom;
            step(r, $urandom_range(3) == 0, $urandom_range(5) == 0, 5'($urandom),
                 $urandom_range(15) == 0, $urandom_range(3) == 0);
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
